// File: rtl/fifo_stream_reader_if.sv
// Streaming output bundle of fifo_stream_reader.
//   out_valid / out_ready : word handshake, transfer when both are high
//   out_data              : stream word
//   out_sop / out_eop     : first / last word of a packet, qualified by out_valid
//   word_idx              : position of the head word within its packet
// master = word producer (the reader), slave = downstream consumer.
interface fifo_stream_reader_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned CWIDTH = 2
);

  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic [CWIDTH-1:0] word_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_sop,
    output out_eop,
    output word_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sop,
    input  out_eop,
    input  word_idx,
    output out_ready
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (read data registered one cycle after rd) and
// presents the words on a valid/ready stream framed into PKT_LEN-word packets.
// A two-entry skid buffer absorbs the FIFO read latency so that one word per
// clock is sustained while the consumer is ready.
// Ports:
//   clk_i         : clock, rising edge
//   srst_n_i      : synchronous reset, active-low
//   fifo_empty_i  : FIFO empty flag (registered in the FIFO)
//   fifo_rd_o     : FIFO read request
//   fifo_rddata_i : FIFO read data, valid the cycle after fifo_rd_o
//   strm          : stream output (valid/ready, data, sop/eop, word index)
module fifo_stream_reader #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CWIDTH  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic                  clk_i,
  input  logic                  srst_n_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  input  logic [DWIDTH-1:0]     fifo_rddata_i,
  fifo_stream_reader_if.master  strm
);

  localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(PKT_LEN - 1);

  logic [DWIDTH-1:0] sk0_q, sk1_q, sk0_d, sk1_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic              inflight_q;
  logic [CWIDTH-1:0] wcnt_q, wcnt_d;
  logic              valid;
  logic              pop;
  logic [2:0]        credit;

  assign valid = (bcnt_q != 2'd0);
  assign pop   = valid & strm.out_ready;

  // Free slots once this cycle's pop is accounted for; an inflight word
  // already owns a slot, so occupancy can never exceed two.
  assign credit    = 3'd2 - 3'(bcnt_q) - 3'(inflight_q) + 3'(pop);
  assign fifo_rd_o = srst_n_i & ~fifo_empty_i & (credit != 3'd0);

  // Next skid contents: shift out on pop, then append the returning word.
  always_comb begin
    sk0_d  = sk0_q;
    sk1_d  = sk1_q;
    bcnt_d = bcnt_q;
    wcnt_d = wcnt_q;
    if (pop) begin
      sk0_d  = sk1_q;
      bcnt_d = bcnt_q - 2'd1;
      wcnt_d = (wcnt_q == LAST_IDX) ? '0 : wcnt_q + CWIDTH'(1);
    end
    if (inflight_q) begin
      if (bcnt_d == 2'd0) begin
        sk0_d = fifo_rddata_i;
      end else begin
        sk1_d = fifo_rddata_i;
      end
      bcnt_d = bcnt_d + 2'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      sk0_q      <= '0;
      sk1_q      <= '0;
      bcnt_q     <= 2'd0;
      inflight_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      sk0_q      <= sk0_d;
      sk1_q      <= sk1_d;
      bcnt_q     <= bcnt_d;
      inflight_q <= fifo_rd_o;
      wcnt_q     <= wcnt_d;
    end
  end

  // Stream outputs come straight from state; framing flags are valid-qualified.
  assign strm.out_valid = valid;
  assign strm.out_data  = sk0_q;
  assign strm.out_sop   = valid & (wcnt_q == '0);
  assign strm.out_eop   = valid & (wcnt_q == LAST_IDX);
  assign strm.word_idx  = wcnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based FIFO model feeds the reader,
// stimulus pushes expected beats into a scoreboard, a monitor compares beats.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned PL = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned EW = DW + 2 + CW;

  logic          clk         = 1'b0;
  logic          srst_n      = 1'b0;
  logic          fifo_empty  = 1'b1;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rddata = '0;
  logic          ready       = 1'b0;

  fifo_stream_reader_if #(.DWIDTH(DW), .CWIDTH(CW)) sif ();
  assign sif.out_ready = ready;

  fifo_stream_reader #(.DWIDTH(DW), .PKT_LEN(PL), .CWIDTH(CW)) dut (
    .clk_i        (clk),
    .srst_n_i     (srst_n),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_o    (fifo_rd),
    .fifo_rddata_i(fifo_rddata),
    .strm         (sif.master)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [EW-1:0] exp_q[$];
  int unsigned   exp_idx = 0;
  int            total = 0;
  int            bad = 0;
  int            rd_cnt = 0;
  int            pop_cnt = 0;
  int            rd_base = 0;
  int            pop_base = 0;
  logic [EW-1:0] mon_exp, mon_act;

  // FIFO model: registered read data and registered empty flag.
  always @(posedge clk) begin
    if (!srst_n) begin
      fifo_empty  <= 1'b1;
      fifo_rddata <= '0;
    end else begin
      if (fifo_rd && fifo_q.size() > 0) fifo_rddata <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: beat scoreboard, read legality and occupancy bound.
  always @(negedge clk) begin
    if (srst_n) begin
      if ((rd_cnt - rd_base) - (pop_cnt - pop_base) > 2) begin
        total++;
        bad++;
        $display("FAIL occupancy: got %0d words held, want <= 2",
                 (rd_cnt - rd_base) - (pop_cnt - pop_base));
      end
      if (fifo_empty) begin
        total++;
        if (fifo_rd) begin
          bad++;
          $display("FAIL rd_while_empty: got fifo_rd=1 want 0 at %0t", $time);
        end
      end
      if (sif.out_valid && ready) begin
        pop_cnt++;
        total++;
        mon_act = {sif.out_data, sif.out_sop, sif.out_eop, sif.word_idx};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got data=%h, want no beat", sif.out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            bad++;
            $display("FAIL beat: got data=%h sop=%b eop=%b idx=%0d want data=%h sop=%b eop=%b idx=%0d",
                     mon_act[EW-1:CW+2], mon_act[CW+1], mon_act[CW], mon_act[CW-1:0],
                     mon_exp[EW-1:CW+2], mon_exp[CW+1], mon_exp[CW], mon_exp[CW-1:0]);
          end
        end
      end
      if (fifo_rd) rd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  // Write a word into the FIFO and predict its framing from stream position.
  task automatic push_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back({d, 1'(exp_idx == 0), 1'(exp_idx == PL - 1), CW'(exp_idx)});
    exp_idx = (exp_idx + 1) % PL;
  endtask

  task automatic do_reset(input int cycles);
    srst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    exp_idx  = 0;
    rd_base  = rd_cnt;
    pop_base = pop_cnt;
    #1;
    check("rd_forced_low_in_reset", int'(fifo_rd), 0);
    repeat (cycles) tick();
    srst_n = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", int'(sif.out_valid), 0);
    check("rst_data", int'(sif.out_data), 0);
    check("rst_sop", int'(sif.out_sop), 0);
    check("rst_eop", int'(sif.out_eop), 0);
    check("rst_idx", int'(sif.word_idx), 0);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int done;
    done = 0;
    for (int c = 0; c < limit && done == 0; c++) begin
      tick();
      if (exp_q.size() == 0 && !sif.out_valid) done = 1;
    end
    check(name, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_rd, t_val, run, maxrun, r0, seen, miss, beats, sop_seen, data_seen, got;

    // Reset and idle with an empty FIFO.
    ready = 1'b1;
    do_reset(3);
    check_reset_outputs();
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_rd", int'(fifo_rd), 0);
      check("idle_valid", int'(sif.out_valid), 0);
    end

    // Eight words, ready held: latency and back-to-back beats.
    for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
    t_rd = -1; t_val = -1; run = 0; maxrun = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (fifo_rd && t_rd < 0) t_rd = c;
      if (sif.out_valid && t_val < 0) t_val = c;
      if (sif.out_valid) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("first_rd_seen", int'(t_rd >= 0), 1);
    check("first_valid_latency", t_val - t_rd, 2);
    check("consecutive_valid", maxrun, 8);
    check("burst_drained", exp_q.size(), 0);

    // Backpressure: only two reads while stalled, head word held.
    ready = 1'b0;
    r0 = rd_cnt;
    for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
    repeat (10) tick();
    check("bp_rd_pulses", rd_cnt - r0, 2);
    check("bp_valid", int'(sif.out_valid), 1);
    check("bp_head_data", int'(sif.out_data), 'h11);
    ready = 1'b1;
    wait_drain("bp_drain", 40);
    check("bp_total_reads", rd_cnt - r0, 8);

    // Ready toggling with a continuous supply: no bubble on ready-high cycles.
    for (int i = 0; i < 40; i++) push_word(8'($urandom));
    seen = 0; miss = 0;
    for (int c = 0; c < 60; c++) begin
      ready = (c % 2 == 0);
      if (ready && sif.out_valid) seen = 1;
      else if (ready && seen != 0) miss++;
      tick();
    end
    check("toggle_no_bubble", miss, 0);
    ready = 1'b1;
    wait_drain("toggle_drain", 60);

    // Single word followed by an empty FIFO.
    r0 = rd_cnt; beats = 0; sop_seen = 0; data_seen = 0;
    push_word(8'hA5);
    for (int c = 0; c < 12; c++) begin
      tick();
      if (sif.out_valid) begin
        beats++;
        sop_seen  = int'(sif.out_sop);
        data_seen = int'(sif.out_data);
      end
    end
    check("single_reads", rd_cnt - r0, 1);
    check("single_beats", beats, 1);
    check("single_sop", sop_seen, 1);
    check("single_data", data_seen, 'hA5);
    check("single_valid_after", int'(sif.out_valid), 0);

    // Mid-packet reset with two buffered words.
    do_reset(1);
    check_reset_outputs();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h31 + 8'(i));
    repeat (6) tick();
    ready = 1'b1;
    repeat (2) tick();
    ready = 1'b0;
    repeat (4) tick();
    check("pre_reset_idx", int'(sif.word_idx), 2);
    check("pre_reset_valid", int'(sif.out_valid), 1);
    do_reset(1);
    check("post_reset_valid", int'(sif.out_valid), 0);
    check("post_reset_idx", int'(sif.word_idx), 0);
    ready = 1'b1;
    push_word(8'h77);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      tick();
      if (sif.out_valid) begin
        got = 1;
        check("post_reset_sop", int'(sif.out_sop), 1);
        check("post_reset_data", int'(sif.out_data), 'h77);
      end
    end
    check("post_reset_beat_seen", got, 1);
    wait_drain("post_reset_drain", 20);

    // Random traffic, random backpressure, occasional reset.
    for (int c = 0; c < 1500; c++) begin
      if (($urandom % 3) != 0 && fifo_q.size() < 12) push_word(8'($urandom));
      ready = (($urandom % 4) != 0);
      if (c % 500 == 499) do_reset(1 + int'($urandom % 2));
      tick();
    end
    ready = 1'b1;
    wait_drain("random_drain", 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
